wb_stage: RTL and testbench
===========================

WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 SHALL have parameter LD_TIMEOUT, default 255, meaning the number of WAIT cycles before pending loads are abandoned (range 1..1023).
REQ-002 SHALL have port clkrst_core_clk, input, 1, the single core clock; all state updates on its rising edge.
REQ-003 SHALL have port clkrst_core_rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port m2wb_valid, input, 1, a 4-lane result bundle is offered.
REQ-005 SHALL have ports m2wb_rd_num0..3, input, 5 each, the destination register or predicate per lane.
REQ-006 SHALL have ports m2wb_rd_data0..3, input, 32 each, the ALU result per lane.
REQ-007 SHALL have ports m2wb_rd_we0..3 and m2wb_pred_we0..3, input, 1 each, the lane GPR and predicate write enables.
REQ-008 SHALL have ports m2wb_ld0..3, input, 1 each, meaning the lane's data comes from a later load response.
REQ-009 SHALL have ports mem2wb_ld_valid (input, 1) and mem2wb_ld_data (input, 32), an in-order load response carrying at most one response per cycle.
REQ-010 SHALL have port wb2m_stall, output, 1, meaning the upstream stage holds its bundle.
REQ-011 SHALL have ports wb2rf_rd_num0..3 (5), wb2rf_rd_data0..3 (32), wb2rf_rd_we0..3 (1) and wb2rf_pred_we0..3 (1), all outputs and all registered.
REQ-012 SHALL have port wb_err, output, 1, a sticky protocol-error flag.

Function
REQ-013 SHALL implement states IDLE and WAIT; wb2m_stall SHALL be 1 exactly when the state is WAIT.
REQ-014 SHALL accept a bundle when m2wb_valid=1 and wb2m_stall=0.
REQ-015 SHALL, for an accepted bundle with no m2wb_ld lane set, drive the wb2rf outputs from that bundle in the next cycle, with a 1-cycle write-enable pulse.
REQ-016 SHALL, for an accepted bundle with any m2wb_ld lane set, capture the bundle, record a pending mask, clear the timeout counter and enter WAIT.
REQ-017 SHALL, in WAIT, write each mem2wb_ld_valid response's data into the lowest-numbered pending lane and clear that lane's pending bit.
REQ-018 SHALL, in the cycle after the last pending bit clears, emit all four lanes' writes together in one pulse and return to IDLE.
REQ-019 SHALL keep enables low in all non-emit cycles and leave num/data holding their last value.
REQ-020 SHALL, if the counter reaches LD_TIMEOUT in WAIT, emit the bundle with the write enables of still-pending lanes forced to 0, set wb_err, and return to IDLE.
REQ-021 SHALL, for a load response arriving in IDLE, drop the response and set wb_err.
REQ-022 SHALL NOT accept a new bundle in the cycle it leaves WAIT, since stall is still 1.
REQ-023 SHALL pass lane ordering unchanged, so the register file's lower-lane-wins rule still resolves duplicate destinations.
REQ-024 SHALL apply write enables exactly as received; the block does no destination conflict checking.

Reset
REQ-025 SHALL, on reset (asynchronous, active-low, including mid-WAIT), enter IDLE and discard the captured bundle and pending mask.
REQ-026 SHALL reset all wb2rf outputs to 0, wb2m_stall to 0, wb_err to 0 and the counter to 0.

Configuration
REQ-027 SHALL, with WB_STAGE_FWD_EN defined, add outputs wb2d_fwd_num0..3, wb2d_fwd_data0..3 and wb2d_fwd_we0..3, carrying the GPR writes being committed this cycle as decode bypass, identical to the wb2rf values.
REQ-028 SHALL, without WB_STAGE_FWD_EN, omit those ports entirely; all other behaviour is unchanged.

Structure
REQ-029 SHALL place the state enum (IDLE/WAIT), NUM_LANES=4 and the lane bundle struct in the shared core package.
REQ-030 SHALL contain one sub-module, wb_ld_fill, holding the pending mask, lowest-pending priority select and timeout counter.

Verification
REQ-031 SHALL cover: bundle with no loads, lane0 rd_num=5, data=0x1234, we0=1 -> next cycle wb2rf_rd_we0=1, num0=5, data0=0x1234, stall never asserted.
REQ-032 SHALL cover: bundle with ld1=1 and ld3=1, responses 0xAAAA then 0xBBBB 2 cycles apart -> stall=1 throughout, then lane1=0xAAAA and lane3=0xBBBB, emitted together one cycle after the second response.
REQ-033 SHALL cover: LD_TIMEOUT=4 with ld2=1 and no response -> after 4 WAIT cycles emit with we2=0 and other lanes written, wb_err=1.
REQ-034 SHALL cover: mem2wb_ld_valid=1 while IDLE -> no write, wb_err=1 and held.
REQ-035 SHALL cover: reset asserted mid-WAIT -> stall=0 and all enables 0 immediately; a later no-load bundle completes normally.
REQ-036 SHALL cover: WB_STAGE_FWD_EN defined -> wb2d_fwd_* equals wb2rf_* on every cycle of the above scenarios.

Source files
------------

// File: rtl/wb_stage_pkg.sv
// Shared core package: writeback state encoding, lane count and lane bundle.
// Imported by wb_stage and wb_ld_fill.
package wb_stage_pkg;

    localparam int NUM_LANES = 4;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } wb_state_e;

    typedef struct packed {
        logic [4:0]  rd_num;
        logic [31:0] rd_data;
        logic        rd_we;
        logic        pred_we;
    } wb_lane_t;

    function automatic logic [NUM_LANES-1:0] lowest_one(
        input logic [NUM_LANES-1:0] m
    );
        return m & (~m + {{(NUM_LANES-1){1'b0}}, 1'b1});
    endfunction

endpackage

// File: rtl/wb_ld_fill.sv
// Load fill tracker: pending lane mask, lowest-pending select and timeout
// counter for the writeback stage.
module wb_ld_fill
    import wb_stage_pkg::*;
#(
    parameter int LD_TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [NUM_LANES-1:0] ld_mask,
    input  logic                 active,
    input  logic                 ld_valid,
    output logic [NUM_LANES-1:0] fill_sel,
    output logic [NUM_LANES-1:0] pending_nxt,
    output logic                 done,
    output logic                 timeout
);

    localparam int CW = 10;

    logic [NUM_LANES-1:0] pending_q, pending_d;
    logic [CW-1:0]        cnt_q, cnt_d;

    always_comb begin
        fill_sel    = '0;
        pending_nxt = pending_q;
        cnt_d       = cnt_q;
        if (active) begin
            if (ld_valid) fill_sel = lowest_one(pending_q);
            pending_nxt = pending_q & ~fill_sel;
            cnt_d       = cnt_q + 1'b1;
        end
        done    = active && (pending_nxt == '0);
        // Fires in the LD_TIMEOUT-th WAIT cycle so stall lasts exactly that long.
        timeout = active && (cnt_q == CW'(LD_TIMEOUT - 1));
        pending_d = pending_nxt;
        if (start) begin
            pending_d = ld_mask;
            cnt_d     = '0;
        end else if (done || timeout) begin
            pending_d = '0;
            cnt_d     = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= '0;
            cnt_q     <= '0;
        end else begin
            pending_q <= pending_d;
            cnt_q     <= cnt_d;
        end
    end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: registers 4-lane results to the register file, stalling
// for in-order load data. Optional decode bypass with WB_STAGE_FWD_EN.
module wb_stage
    import wb_stage_pkg::*;
#(
    parameter int LD_TIMEOUT = 255
) (
    input  logic        clkrst_core_clk,
    input  logic        clkrst_core_rst_n,
    input  logic        m2wb_valid,
    input  logic [4:0]  m2wb_rd_num0,
    input  logic [4:0]  m2wb_rd_num1,
    input  logic [4:0]  m2wb_rd_num2,
    input  logic [4:0]  m2wb_rd_num3,
    input  logic [31:0] m2wb_rd_data0,
    input  logic [31:0] m2wb_rd_data1,
    input  logic [31:0] m2wb_rd_data2,
    input  logic [31:0] m2wb_rd_data3,
    input  logic        m2wb_rd_we0,
    input  logic        m2wb_rd_we1,
    input  logic        m2wb_rd_we2,
    input  logic        m2wb_rd_we3,
    input  logic        m2wb_pred_we0,
    input  logic        m2wb_pred_we1,
    input  logic        m2wb_pred_we2,
    input  logic        m2wb_pred_we3,
    input  logic        m2wb_ld0,
    input  logic        m2wb_ld1,
    input  logic        m2wb_ld2,
    input  logic        m2wb_ld3,
    input  logic        mem2wb_ld_valid,
    input  logic [31:0] mem2wb_ld_data,
    output logic        wb2m_stall,
    output logic [4:0]  wb2rf_rd_num0,
    output logic [4:0]  wb2rf_rd_num1,
    output logic [4:0]  wb2rf_rd_num2,
    output logic [4:0]  wb2rf_rd_num3,
    output logic [31:0] wb2rf_rd_data0,
    output logic [31:0] wb2rf_rd_data1,
    output logic [31:0] wb2rf_rd_data2,
    output logic [31:0] wb2rf_rd_data3,
    output logic        wb2rf_rd_we0,
    output logic        wb2rf_rd_we1,
    output logic        wb2rf_rd_we2,
    output logic        wb2rf_rd_we3,
    output logic        wb2rf_pred_we0,
    output logic        wb2rf_pred_we1,
    output logic        wb2rf_pred_we2,
    output logic        wb2rf_pred_we3,
    output logic        wb_err
`ifdef WB_STAGE_FWD_EN
    ,
    output logic [4:0]  wb2d_fwd_num0,
    output logic [4:0]  wb2d_fwd_num1,
    output logic [4:0]  wb2d_fwd_num2,
    output logic [4:0]  wb2d_fwd_num3,
    output logic [31:0] wb2d_fwd_data0,
    output logic [31:0] wb2d_fwd_data1,
    output logic [31:0] wb2d_fwd_data2,
    output logic [31:0] wb2d_fwd_data3,
    output logic        wb2d_fwd_we0,
    output logic        wb2d_fwd_we1,
    output logic        wb2d_fwd_we2,
    output logic        wb2d_fwd_we3
`endif
);

    wb_state_e                 state_q, state_d;
    wb_lane_t [NUM_LANES-1:0]  in_lane;
    wb_lane_t [NUM_LANES-1:0]  bnd_q, bnd_d;
    wb_lane_t [NUM_LANES-1:0]  out_q, out_d;
    logic [NUM_LANES-1:0]      ld_vec;
    logic [NUM_LANES-1:0]      fill_sel, pending_nxt;
    logic                      err_q, err_d;
    logic                      accept, fill_start, done, timeout;

    always_comb begin
        in_lane[0] = '{m2wb_rd_num0, m2wb_rd_data0, m2wb_rd_we0, m2wb_pred_we0};
        in_lane[1] = '{m2wb_rd_num1, m2wb_rd_data1, m2wb_rd_we1, m2wb_pred_we1};
        in_lane[2] = '{m2wb_rd_num2, m2wb_rd_data2, m2wb_rd_we2, m2wb_pred_we2};
        in_lane[3] = '{m2wb_rd_num3, m2wb_rd_data3, m2wb_rd_we3, m2wb_pred_we3};
        ld_vec     = {m2wb_ld3, m2wb_ld2, m2wb_ld1, m2wb_ld0};
    end

    assign wb2m_stall = (state_q == WAIT);
    assign accept     = m2wb_valid && (state_q == IDLE);
    assign fill_start = accept && (|ld_vec);

    wb_ld_fill #(
        .LD_TIMEOUT (LD_TIMEOUT)
    ) u_fill (
        .clk         (clkrst_core_clk),
        .rst_n       (clkrst_core_rst_n),
        .start       (fill_start),
        .ld_mask     (ld_vec),
        .active      (state_q == WAIT),
        .ld_valid    (mem2wb_ld_valid),
        .fill_sel    (fill_sel),
        .pending_nxt (pending_nxt),
        .done        (done),
        .timeout     (timeout)
    );

    always_comb begin
        state_d = state_q;
        bnd_d   = bnd_q;
        out_d   = out_q;
        err_d   = err_q;
        for (int i = 0; i < NUM_LANES; i++) begin
            out_d[i].rd_we   = 1'b0;
            out_d[i].pred_we = 1'b0;
        end
        unique case (state_q)
            IDLE: begin
                if (mem2wb_ld_valid) err_d = 1'b1;
                if (accept) begin
                    if (|ld_vec) begin
                        bnd_d   = in_lane;
                        state_d = WAIT;
                    end else begin
                        out_d = in_lane;
                    end
                end
            end
            WAIT: begin
                for (int i = 0; i < NUM_LANES; i++)
                    if (fill_sel[i]) bnd_d[i].rd_data = mem2wb_ld_data;
                if (done || timeout) begin
                    out_d = bnd_d;
                    // Lanes whose load never arrived must not write.
                    for (int i = 0; i < NUM_LANES; i++) begin
                        if (pending_nxt[i]) begin
                            out_d[i].rd_we   = 1'b0;
                            out_d[i].pred_we = 1'b0;
                        end
                    end
                    if (!done) err_d = 1'b1;
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clkrst_core_clk or negedge clkrst_core_rst_n) begin
        if (!clkrst_core_rst_n) begin
            state_q <= IDLE;
            bnd_q   <= '0;
            out_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            bnd_q   <= bnd_d;
            out_q   <= out_d;
            err_q   <= err_d;
        end
    end

    assign wb_err         = err_q;
    assign wb2rf_rd_num0  = out_q[0].rd_num;
    assign wb2rf_rd_num1  = out_q[1].rd_num;
    assign wb2rf_rd_num2  = out_q[2].rd_num;
    assign wb2rf_rd_num3  = out_q[3].rd_num;
    assign wb2rf_rd_data0 = out_q[0].rd_data;
    assign wb2rf_rd_data1 = out_q[1].rd_data;
    assign wb2rf_rd_data2 = out_q[2].rd_data;
    assign wb2rf_rd_data3 = out_q[3].rd_data;
    assign wb2rf_rd_we0   = out_q[0].rd_we;
    assign wb2rf_rd_we1   = out_q[1].rd_we;
    assign wb2rf_rd_we2   = out_q[2].rd_we;
    assign wb2rf_rd_we3   = out_q[3].rd_we;
    assign wb2rf_pred_we0 = out_q[0].pred_we;
    assign wb2rf_pred_we1 = out_q[1].pred_we;
    assign wb2rf_pred_we2 = out_q[2].pred_we;
    assign wb2rf_pred_we3 = out_q[3].pred_we;

`ifdef WB_STAGE_FWD_EN
    assign wb2d_fwd_num0  = out_q[0].rd_num;
    assign wb2d_fwd_num1  = out_q[1].rd_num;
    assign wb2d_fwd_num2  = out_q[2].rd_num;
    assign wb2d_fwd_num3  = out_q[3].rd_num;
    assign wb2d_fwd_data0 = out_q[0].rd_data;
    assign wb2d_fwd_data1 = out_q[1].rd_data;
    assign wb2d_fwd_data2 = out_q[2].rd_data;
    assign wb2d_fwd_data3 = out_q[3].rd_data;
    assign wb2d_fwd_we0   = out_q[0].rd_we;
    assign wb2d_fwd_we1   = out_q[1].rd_we;
    assign wb2d_fwd_we2   = out_q[2].rd_we;
    assign wb2d_fwd_we3   = out_q[3].rd_we;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage (LD_TIMEOUT=4); forward-port checks are
// compiled in when WB_STAGE_FWD_EN is defined.
module tb_wb_stage;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        valid;
    logic [4:0]  rd_num [4];
    logic [31:0] rd_data [4];
    logic        rd_we [4];
    logic        pred_we [4];
    logic        ld [4];
    logic        ld_valid;
    logic [31:0] ld_data;

    wire         stall;
    wire         err;
    wire [4:0]   o_num [4];
    wire [31:0]  o_data [4];
    wire         o_we [4];
    wire         o_pwe [4];

    int n_tests = 0;
    int n_fail  = 0;

`ifdef WB_STAGE_FWD_EN
    wire [4:0]  f_num [4];
    wire [31:0] f_data [4];
    wire        f_we [4];
`endif

    wb_stage #(.LD_TIMEOUT(4)) dut (
        .clkrst_core_clk   (clk),
        .clkrst_core_rst_n (rst_n),
        .m2wb_valid        (valid),
        .m2wb_rd_num0      (rd_num[0]),
        .m2wb_rd_num1      (rd_num[1]),
        .m2wb_rd_num2      (rd_num[2]),
        .m2wb_rd_num3      (rd_num[3]),
        .m2wb_rd_data0     (rd_data[0]),
        .m2wb_rd_data1     (rd_data[1]),
        .m2wb_rd_data2     (rd_data[2]),
        .m2wb_rd_data3     (rd_data[3]),
        .m2wb_rd_we0       (rd_we[0]),
        .m2wb_rd_we1       (rd_we[1]),
        .m2wb_rd_we2       (rd_we[2]),
        .m2wb_rd_we3       (rd_we[3]),
        .m2wb_pred_we0     (pred_we[0]),
        .m2wb_pred_we1     (pred_we[1]),
        .m2wb_pred_we2     (pred_we[2]),
        .m2wb_pred_we3     (pred_we[3]),
        .m2wb_ld0          (ld[0]),
        .m2wb_ld1          (ld[1]),
        .m2wb_ld2          (ld[2]),
        .m2wb_ld3          (ld[3]),
        .mem2wb_ld_valid   (ld_valid),
        .mem2wb_ld_data    (ld_data),
        .wb2m_stall        (stall),
        .wb2rf_rd_num0     (o_num[0]),
        .wb2rf_rd_num1     (o_num[1]),
        .wb2rf_rd_num2     (o_num[2]),
        .wb2rf_rd_num3     (o_num[3]),
        .wb2rf_rd_data0    (o_data[0]),
        .wb2rf_rd_data1    (o_data[1]),
        .wb2rf_rd_data2    (o_data[2]),
        .wb2rf_rd_data3    (o_data[3]),
        .wb2rf_rd_we0      (o_we[0]),
        .wb2rf_rd_we1      (o_we[1]),
        .wb2rf_rd_we2      (o_we[2]),
        .wb2rf_rd_we3      (o_we[3]),
        .wb2rf_pred_we0    (o_pwe[0]),
        .wb2rf_pred_we1    (o_pwe[1]),
        .wb2rf_pred_we2    (o_pwe[2]),
        .wb2rf_pred_we3    (o_pwe[3]),
        .wb_err            (err)
`ifdef WB_STAGE_FWD_EN
        ,
        .wb2d_fwd_num0     (f_num[0]),
        .wb2d_fwd_num1     (f_num[1]),
        .wb2d_fwd_num2     (f_num[2]),
        .wb2d_fwd_num3     (f_num[3]),
        .wb2d_fwd_data0    (f_data[0]),
        .wb2d_fwd_data1    (f_data[1]),
        .wb2d_fwd_data2    (f_data[2]),
        .wb2d_fwd_data3    (f_data[3]),
        .wb2d_fwd_we0      (f_we[0]),
        .wb2d_fwd_we1      (f_we[1]),
        .wb2d_fwd_we2      (f_we[2]),
        .wb2d_fwd_we3      (f_we[3])
`endif
    );

`ifdef WB_STAGE_FWD_EN
    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (f_num[i] !== o_num[i] || f_data[i] !== o_data[i] ||
                f_we[i] !== o_we[i]) begin
                n_fail++;
                $display("FAIL fwd lane%0d got %0d/%h/%b want %0d/%h/%b",
                         i, f_num[i], f_data[i], f_we[i],
                         o_num[i], o_data[i], o_we[i]);
            end
        end
    end
`endif

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        valid    = 1'b0;
        ld_valid = 1'b0;
        ld_data  = '0;
        for (int i = 0; i < 4; i++) begin
            rd_num[i]  = '0;
            rd_data[i] = '0;
            rd_we[i]   = 1'b0;
            pred_we[i] = 1'b0;
            ld[i]      = 1'b0;
        end
    endtask

    task automatic set_lane(input int i, input logic [4:0] n,
                            input logic [31:0] d, input logic we,
                            input logic pwe, input logic l);
        rd_num[i]  = n;
        rd_data[i] = d;
        rd_we[i]   = we;
        pred_we[i] = pwe;
        ld[i]      = l;
    endtask

    task automatic apply_reset();
        clear_in();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        clear_in();
        #12;
        n_tests++;
        if (stall !== 1'b0 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset stall/err got %b/%b want 0/0", stall, err);
        end
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (o_we[i] !== 1'b0 || o_pwe[i] !== 1'b0 ||
                o_num[i] !== 5'd0 || o_data[i] !== 32'd0) begin
                n_fail++;
                $display("FAIL reset lane%0d got %b%b %0d %h want 00 0 0",
                         i, o_we[i], o_pwe[i], o_num[i], o_data[i]);
            end
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_no_load();
        logic [4:0]  en [4];
        logic [31:0] ed [4];
        logic        ew [4];
        logic        ep [4];
        clear_in();
        set_lane(0, 5'd5, 32'h1234, 1'b1, 1'b0, 1'b0);
        set_lane(1, 5'd6, 32'h5678, 1'b0, 1'b0, 1'b0);
        valid = 1'b1;
        n_tests++;
        if (stall !== 1'b0) begin
            n_fail++;
            $display("FAIL no_load pre stall got %b want 0", stall);
        end
        tick();
        valid = 1'b0;
        n_tests++;
        if (o_we[0] !== 1'b1 || o_num[0] !== 5'd5 ||
            o_data[0] !== 32'h1234 || stall !== 1'b0) begin
            n_fail++;
            $display("FAIL no_load lane0 got we=%b num=%0d data=%h stall=%b want 1 5 1234 0",
                     o_we[0], o_num[0], o_data[0], stall);
        end
        n_tests++;
        if (o_we[1] !== 1'b0 || o_we[2] !== 1'b0 || o_we[3] !== 1'b0) begin
            n_fail++;
            $display("FAIL no_load other we got %b%b%b want 000",
                     o_we[1], o_we[2], o_we[3]);
        end
        tick();
        n_tests++;
        if (o_we[0] !== 1'b0 || o_num[0] !== 5'd5 || o_data[0] !== 32'h1234) begin
            n_fail++;
            $display("FAIL no_load hold got we=%b num=%0d data=%h want 0 5 1234",
                     o_we[0], o_num[0], o_data[0]);
        end
        en = '{5'd1, 5'd2, 5'd3, 5'd3};
        ed = '{32'hA, 32'hB, 32'hC, 32'hD};
        ew = '{1'b1, 1'b0, 1'b1, 1'b1};
        ep = '{1'b0, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) set_lane(i, en[i], ed[i], ew[i], ep[i], 1'b0);
        valid = 1'b1;
        tick();
        valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (o_num[i] !== en[i] || o_data[i] !== ed[i] ||
                o_we[i] !== ew[i] || o_pwe[i] !== ep[i]) begin
                n_fail++;
                $display("FAIL all_lanes lane%0d got %0d %h %b%b want %0d %h %b%b",
                         i, o_num[i], o_data[i], o_we[i], o_pwe[i],
                         en[i], ed[i], ew[i], ep[i]);
            end
        end
        tick();
    endtask

    task automatic test_two_loads();
        clear_in();
        set_lane(0, 5'd1, 32'h11, 1'b1, 1'b0, 1'b0);
        set_lane(1, 5'd2, 32'h0,  1'b1, 1'b0, 1'b1);
        set_lane(2, 5'd3, 32'h33, 1'b0, 1'b1, 1'b0);
        set_lane(3, 5'd4, 32'h0,  1'b1, 1'b0, 1'b1);
        valid = 1'b1;
        tick();
        clear_in();
        n_tests++;
        if (stall !== 1'b1 || o_we[0] !== 1'b0 || o_pwe[2] !== 1'b0) begin
            n_fail++;
            $display("FAIL two_loads w1 stall=%b we0=%b pwe2=%b want 1 0 0",
                     stall, o_we[0], o_pwe[2]);
        end
        ld_valid = 1'b1;
        ld_data  = 32'hAAAA;
        tick();
        ld_valid = 1'b0;
        n_tests++;
        if (stall !== 1'b1 || o_we[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL two_loads w2 stall=%b we1=%b want 1 0", stall, o_we[1]);
        end
        tick();
        n_tests++;
        if (stall !== 1'b1) begin
            n_fail++;
            $display("FAIL two_loads w3 stall got %b want 1", stall);
        end
        ld_valid = 1'b1;
        ld_data  = 32'hBBBB;
        set_lane(0, 5'd9, 32'h99, 1'b1, 1'b0, 1'b0);
        valid = 1'b1;
        tick();
        ld_valid = 1'b0;
        n_tests++;
        if (stall !== 1'b0 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL two_loads emit stall/err got %b/%b want 0/0", stall, err);
        end
        n_tests++;
        if (o_we[0] !== 1'b1 || o_num[0] !== 5'd1 || o_data[0] !== 32'h11) begin
            n_fail++;
            $display("FAIL two_loads lane0 got %b %0d %h want 1 1 11",
                     o_we[0], o_num[0], o_data[0]);
        end
        n_tests++;
        if (o_we[1] !== 1'b1 || o_num[1] !== 5'd2 || o_data[1] !== 32'hAAAA) begin
            n_fail++;
            $display("FAIL two_loads lane1 got %b %0d %h want 1 2 aaaa",
                     o_we[1], o_num[1], o_data[1]);
        end
        n_tests++;
        if (o_we[2] !== 1'b0 || o_pwe[2] !== 1'b1 || o_num[2] !== 5'd3 ||
            o_data[2] !== 32'h33) begin
            n_fail++;
            $display("FAIL two_loads lane2 got %b%b %0d %h want 01 3 33",
                     o_we[2], o_pwe[2], o_num[2], o_data[2]);
        end
        n_tests++;
        if (o_we[3] !== 1'b1 || o_num[3] !== 5'd4 || o_data[3] !== 32'hBBBB) begin
            n_fail++;
            $display("FAIL two_loads lane3 got %b %0d %h want 1 4 bbbb",
                     o_we[3], o_num[3], o_data[3]);
        end
        tick();
        valid = 1'b0;
        n_tests++;
        if (o_we[0] !== 1'b1 || o_num[0] !== 5'd9 || o_data[0] !== 32'h99 ||
            o_we[1] !== 1'b0 || o_we[3] !== 1'b0) begin
            n_fail++;
            $display("FAIL back_to_back got we0=%b num0=%0d data0=%h we1=%b we3=%b want 1 9 99 0 0",
                     o_we[0], o_num[0], o_data[0], o_we[1], o_we[3]);
        end
        tick();
        n_tests++;
        if (o_we[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL back_to_back pulse we0 got %b want 0", o_we[0]);
        end
    endtask

    task automatic test_timeout();
        clear_in();
        set_lane(0, 5'd7,  32'h70,  1'b1, 1'b0, 1'b0);
        set_lane(1, 5'd8,  32'h80,  1'b1, 1'b0, 1'b0);
        set_lane(2, 5'd10, 32'h100, 1'b1, 1'b0, 1'b1);
        set_lane(3, 5'd2,  32'h1,   1'b0, 1'b1, 1'b0);
        valid = 1'b1;
        tick();
        valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            n_tests++;
            if (stall !== 1'b1 || err !== 1'b0 || o_we[0] !== 1'b0) begin
                n_fail++;
                $display("FAIL timeout wait%0d stall=%b err=%b we0=%b want 1 0 0",
                         k, stall, err, o_we[0]);
            end
            tick();
        end
        n_tests++;
        if (stall !== 1'b0 || err !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout emit stall/err got %b/%b want 0/1", stall, err);
        end
        n_tests++;
        if (o_we[0] !== 1'b1 || o_we[1] !== 1'b1 || o_we[2] !== 1'b0 ||
            o_pwe[3] !== 1'b1 || o_num[0] !== 5'd7 || o_data[1] !== 32'h80) begin
            n_fail++;
            $display("FAIL timeout lanes we=%b%b%b pwe3=%b num0=%0d data1=%h want 110 1 7 80",
                     o_we[0], o_we[1], o_we[2], o_pwe[3], o_num[0], o_data[1]);
        end
        tick();
        n_tests++;
        if (err !== 1'b1 || o_we[0] !== 1'b0 || o_pwe[3] !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout after err=%b we0=%b pwe3=%b want 1 0 0",
                     err, o_we[0], o_pwe[3]);
        end
    endtask

    task automatic test_idle_resp();
        apply_reset();
        n_tests++;
        if (err !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_resp pre err got %b want 0", err);
        end
        ld_valid = 1'b1;
        ld_data  = 32'hDEAD;
        tick();
        ld_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (o_we[i] !== 1'b0 || o_pwe[i] !== 1'b0 || o_data[i] !== 32'd0) begin
                n_fail++;
                $display("FAIL idle_resp lane%0d got %b%b %h want 00 0",
                         i, o_we[i], o_pwe[i], o_data[i]);
            end
        end
        n_tests++;
        if (err !== 1'b1 || stall !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_resp err/stall got %b/%b want 1/0", err, stall);
        end
        tick();
        tick();
        n_tests++;
        if (err !== 1'b1) begin
            n_fail++;
            $display("FAIL idle_resp sticky err got %b want 1", err);
        end
    endtask

    task automatic test_reset_mid_wait();
        clear_in();
        set_lane(0, 5'd3, 32'h33, 1'b1, 1'b0, 1'b0);
        valid = 1'b1;
        tick();
        set_lane(0, 5'd4, 32'h0, 1'b1, 1'b0, 1'b1);
        tick();
        clear_in();
        n_tests++;
        if (stall !== 1'b1 || o_num[0] !== 5'd3) begin
            n_fail++;
            $display("FAIL mid_wait pre stall=%b num0=%0d want 1 3", stall, o_num[0]);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (stall !== 1'b0 || err !== 1'b0 || o_num[0] !== 5'd0 ||
            o_data[0] !== 32'd0) begin
            n_fail++;
            $display("FAIL mid_wait rst stall=%b err=%b num0=%0d data0=%h want 0 0 0 0",
                     stall, err, o_num[0], o_data[0]);
        end
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (o_we[i] !== 1'b0 || o_pwe[i] !== 1'b0) begin
                n_fail++;
                $display("FAIL mid_wait rst lane%0d we got %b%b want 00",
                         i, o_we[i], o_pwe[i]);
            end
        end
        rst_n = 1'b1;
        tick();
        set_lane(1, 5'd12, 32'hC0DE, 1'b1, 1'b0, 1'b0);
        valid = 1'b1;
        n_tests++;
        if (stall !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_wait post stall got %b want 0", stall);
        end
        tick();
        valid = 1'b0;
        n_tests++;
        if (o_we[1] !== 1'b1 || o_num[1] !== 5'd12 || o_data[1] !== 32'hC0DE ||
            o_we[0] !== 1'b0 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_wait after got we1=%b num1=%0d data1=%h we0=%b err=%b want 1 12 c0de 0 0",
                     o_we[1], o_num[1], o_data[1], o_we[0], err);
        end
        tick();
    endtask

    initial begin
        clear_in();
        test_reset();
        test_no_load();
        test_two_loads();
        test_timeout();
        test_idle_resp();
        test_reset_mid_wait();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
